msg_schedule_stream: RTL and testbench
======================================

# msg_schedule_stream

Parametrised SHA-2 message-schedule expander. It accepts one 16-word padded message block and streams the round words W_0..W_{ROUNDS-1}, one per handshake, into the compression core. It supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds). Expansion uses a 16-entry rolling window instead of a full schedule vector, with valid/ready backpressure on both sides.

## Interface
- WORD_W, 32, word width; only 32 (SHA-256) or 64 (SHA-512) is legal, any other value is an elaboration error.
- ROUNDS, derived (64 when WORD_W=32, 80 when WORD_W=64), number of schedule words per block; not overridable.
- IDX_W, derived $clog2(ROUNDS), width of w_index.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- abort  in  1  drop the current block and return to IDLE.
- block_valid  in  1  block_data is valid.
- block_ready  out  1  block can be accepted this cycle.
- block_data  in  16*WORD_W  padded block, big-endian: M_0 = block_data[16*WORD_W-1 -: WORD_W].
- w_valid  out  1  w_data holds a valid schedule word.
- w_ready  in  1  consumer accepts w_data.
- w_data  out  WORD_W  schedule word W_t.
- w_index  out  IDX_W  t of the current w_data.
- w_last  out  1  w_valid and w_index == ROUNDS-1.
- busy  out  1  a block is loaded and not yet fully streamed.

## Operation
- States: IDLE and RUN. Registers: win[0..15] (WORD_W each), t (IDX_W).
- IDLE:
  - block_ready=1.
  - On block_valid&&block_ready: win[i] <= M_i, t <= 0, go to RUN.
- RUN:
  - w_valid=1, w_data=win[0], w_index=t.
  - On w_valid&&w_ready (a beat): win[i] <= win[i+1] for i=0..14; win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], modulo 2^WORD_W; t <= t+1.
- Window invariant in RUN: win[k] = W_{t+k}. The expansion word is computed on every beat, including beats with t ≥ ROUNDS-16; the words it produces there are discarded.
- σ functions, WORD_W=32: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
- σ functions, WORD_W=64: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
- Last beat (w_last && w_ready):
  - Go to IDLE and clear t.
  - block_ready is also asserted in that same cycle (block_ready = IDLE | (w_last & w_ready)).
  - If block_valid is high then, the new block loads and the state stays RUN with t=0. This gives back-to-back blocks with no bubble.
- abort (priority below reset, above everything else):
  - Next state IDLE, t=0, w_valid=0 next cycle.
  - A simultaneous block handshake is ignored; block_ready is forced 0 while abort=1.
  - A simultaneous w beat is still counted as consumed by the sink; the block discards it.
- Holding rule: when w_valid=1 and w_ready=0, w_data, w_index and w_last hold stable.

## Timing
- Reset (synchronous): state IDLE, t=0, win cleared to 0, w_valid=0, w_last=0, busy=0, w_data=0, w_index=0. block_ready is forced 0 while reset=1 and goes to 1 in the first cycle after reset deasserts.
- Latency: block accepted at edge N gives w_valid=1 with W_0 in the cycle after edge N.
- Full-rate throughput: ROUNDS cycles per block with w_ready tied high, and zero idle cycles between consecutive blocks.
- All outputs are registers or decode of state/t/win only. The single exception is block_ready, which depends combinationally on w_ready and abort.
- Critical path: two σ + a 4-operand adder, WORD_W wide. No internal pipelining.

## Structure
- Shared package sha2_pkg holds:
  - ROUNDS_FOR(WORD_W) function.
  - σ rotate/shift constants per word width.
  - State enum {IDLE, RUN}.
- One sub-module: sha2_sigma_small.
  - Parameters: WORD_W, SEL (0 = σ0, 1 = σ1).
  - Combinational function block.
  - Instantiated twice.

## Test plan
- SHA-256 "abc" block (M_0=0x61626380, M_1..M_14=0, M_15=0x00000018), w_ready=1: W_0=0x61626380, W_15=0x00000018, W_16=0x61626380, W_17=0x000F0000. w_last fires at t=63, and all 64 words match the golden model.
- SHA-512 "abc" block (M_0=0x6162638000000000, M_15=0x18), w_ready=1: W_16=0x6162638000000000. w_last fires at t=79, and all 80 words match the model.
- Random w_ready (50%) on the "abc" block: w_data/w_index stay stable while stalled, there are exactly 64 beats, and the sequence is identical to the full-rate run.
- Two blocks with block_valid held high: the second block's W_0 appears in the cycle after the first block's w_last beat, with no w_valid gap.
- abort at t=20 with a simultaneous block_valid: w_valid=0 next cycle and the block is not accepted. The next block then streams from t=0 correctly.
- reset asserted mid-block at t=40: all outputs take reset values the next cycle, block_ready=1 after release, and a fresh block streams correctly.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message-schedule expander.
//   ROUNDS_FOR  : number of schedule words per block for a given word width
//   SIGMA_CONST : rotate/shift amounts of the small sigma functions
//   state_t     : expander state encoding
package sha2_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int ROUNDS_FOR(input int word_w);
        return (word_w == 64) ? 80 : 64;
    endfunction

    // k = 0: first rotate, k = 1: second rotate, k = 2: right shift.
    // sel = 0 selects sigma0, sel = 1 selects sigma1.
    function automatic int SIGMA_CONST(input int word_w, input int sel, input int k);
        int amt;
        amt = 0;
        if (word_w == 64) begin
            if (sel == 0) amt = (k == 0) ? 1  : (k == 1) ? 8  : 7;
            else          amt = (k == 0) ? 19 : (k == 1) ? 61 : 6;
        end else begin
            if (sel == 0) amt = (k == 0) ? 7  : (k == 1) ? 18 : 3;
            else          amt = (k == 0) ? 17 : (k == 1) ? 19 : 10;
        end
        return amt;
    endfunction

endpackage

// File: rtl/sha2_sigma_small.sv
// Small sigma function of the SHA-2 message schedule (purely combinational).
//   WORD_W : 32 or 64
//   SEL    : 0 = sigma0, 1 = sigma1
// Ports:
//   x : input word
//   y : ROTR(a) ^ ROTR(b) ^ SHR(c) of x
module sha2_sigma_small
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int SEL    = 0
) (
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    localparam int ROT_A = SIGMA_CONST(WORD_W, SEL, 0);
    localparam int ROT_B = SIGMA_CONST(WORD_W, SEL, 1);
    localparam int SHR_C = SIGMA_CONST(WORD_W, SEL, 2);

    logic [WORD_W-1:0] rot_a;
    logic [WORD_W-1:0] rot_b;
    logic [WORD_W-1:0] shr_c;

    assign rot_a = (x >> ROT_A) | (x << (WORD_W - ROT_A));
    assign rot_b = (x >> ROT_B) | (x << (WORD_W - ROT_B));
    assign shr_c = x >> SHR_C;
    assign y     = rot_a ^ rot_b ^ shr_c;

endmodule

// File: rtl/msg_schedule_stream.sv
// SHA-2 message-schedule expander. Loads one 16-word padded block and streams
// W_0..W_{ROUNDS-1} over a valid/ready interface using a 16-word rolling window.
// Ports:
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   abort                      : drop the current block, return to IDLE
//   block_valid/ready/data     : block input, M_0 in the most significant word
//   w_valid/ready/data/index   : schedule word output and its round number
//   w_last                     : current word is W_{ROUNDS-1}
//   busy                       : a block is loaded and not fully streamed
module msg_schedule_stream
    import sha2_pkg::*;
#(
    parameter  int WORD_W = 32,
    localparam int ROUNDS = ROUNDS_FOR(WORD_W),
    localparam int IDX_W  = $clog2(ROUNDS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 abort,
    input  logic                 block_valid,
    output logic                 block_ready,
    input  logic [16*WORD_W-1:0] block_data,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w_data,
    output logic [IDX_W-1:0]     w_index,
    output logic                 w_last,
    output logic                 busy
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("msg_schedule_stream: WORD_W must be 32 or 64");
    end

    state_t            state;
    logic [WORD_W-1:0] win [16];
    logic [IDX_W-1:0]  t;

    logic [WORD_W-1:0] sig0;
    logic [WORD_W-1:0] sig1;
    logic [WORD_W-1:0] next_word;
    logic              beat;
    logic              load;

    sha2_sigma_small #(.WORD_W(WORD_W), .SEL(0)) u_sigma0 (.x(win[1]),  .y(sig0));
    sha2_sigma_small #(.WORD_W(WORD_W), .SEL(1)) u_sigma1 (.x(win[14]), .y(sig1));

    // win[k] holds W_{t+k}, so this is W_{t+16}. Past round ROUNDS-16 the
    // result is never emitted; computing it anyway keeps the shift uniform.
    assign next_word = sig1 + win[9] + sig0 + win[0];

    assign w_valid = (state == RUN);
    assign busy    = (state == RUN);
    assign w_data  = win[0];
    assign w_index = t;
    assign w_last  = (state == RUN) && (t == IDX_W'(ROUNDS - 1));

    // Ready on the final beat as well, so a queued block follows with no bubble.
    assign block_ready = !reset && !abort && ((state == IDLE) || (w_last && w_ready));

    assign beat = w_valid && w_ready;
    assign load = block_valid && block_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (abort) begin
            state <= IDLE;
            t     <= '0;
        end else if (load) begin
            state <= RUN;
            t     <= '0;
            for (int i = 0; i < 16; i++) win[i] <= block_data[(16-i)*WORD_W-1 -: WORD_W];
        end else if (beat) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= next_word;
            if (w_last) begin
                state <= IDLE;
                t     <= '0;
            end else begin
                t <= t + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msg_schedule_stream.sv
// Self-checking bench for msg_schedule_stream: one SHA-256 and one SHA-512
// instance, each compared with a full-array schedule model.
module tb_msg_schedule_stream;

    typedef logic [63:0] blk_t   [16];
    typedef logic [63:0] sched_t [80];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          abort;
    logic          blk_valid;
    logic          w_ready;
    logic          sel64;
    logic [1023:0] blk_data;

    logic          block_valid32, block_ready32, w_valid32, w_last32, busy32;
    logic [31:0]   w_data32;
    logic [5:0]    w_index32;
    logic          block_valid64, block_ready64, w_valid64, w_last64, busy64;
    logic [63:0]   w_data64;
    logic [6:0]    w_index64;

    logic          obs_valid, obs_last, obs_busy, obs_bready;
    logic [63:0]   obs_data;
    logic [6:0]    obs_index;

    int errors = 0;
    int checks = 0;

    assign block_valid32 = blk_valid && !sel64;
    assign block_valid64 = blk_valid && sel64;

    assign obs_valid  = sel64 ? w_valid64     : w_valid32;
    assign obs_last   = sel64 ? w_last64      : w_last32;
    assign obs_busy   = sel64 ? busy64        : busy32;
    assign obs_bready = sel64 ? block_ready64 : block_ready32;
    assign obs_data   = sel64 ? w_data64      : {32'h0, w_data32};
    assign obs_index  = sel64 ? w_index64     : {1'b0, w_index32};

    msg_schedule_stream #(.WORD_W(32)) dut32 (
        .clock(clock), .reset(reset), .abort(abort),
        .block_valid(block_valid32), .block_ready(block_ready32),
        .block_data(blk_data[511:0]),
        .w_valid(w_valid32), .w_ready(w_ready), .w_data(w_data32),
        .w_index(w_index32), .w_last(w_last32), .busy(busy32)
    );

    msg_schedule_stream #(.WORD_W(64)) dut64 (
        .clock(clock), .reset(reset), .abort(abort),
        .block_valid(block_valid64), .block_ready(block_ready64),
        .block_data(blk_data),
        .w_valid(w_valid64), .w_ready(w_ready), .w_data(w_data64),
        .w_index(w_index64), .w_last(w_last64), .busy(busy64)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int r, input int w);
        logic [31:0] x32;
        x32 = x[31:0];
        if (w == 32) return {32'h0, (x32 >> r) | (x32 << (32 - r))};
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
        return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input int w);
        if (w == 32) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
        return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    endfunction

    task automatic build_sched(input int w, input blk_t m, output sched_t ws);
        logic [63:0] msk;
        msk = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
        for (int i = 0; i < 80; i++) begin
            if (i < 16) ws[i] = m[i] & msk;
            else ws[i] = (ssig1(ws[i-2], w) + ws[i-7] + ssig0(ws[i-15], w) + ws[i-16]) & msk;
        end
    endtask

    function automatic logic [1023:0] pack(input int w, input blk_t m);
        logic [1023:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            if (w == 32) d[511-32*i -: 32] = m[i][31:0];
            else         d[1023-64*i -: 64] = m[i];
        end
        return d;
    endfunction

    function automatic blk_t rand_block(input int w);
        blk_t m;
        for (int i = 0; i < 16; i++)
            m[i] = (w == 32) ? {32'h0, $urandom} : {$urandom, $urandom};
        return m;
    endfunction

    function automatic blk_t abc_block(input int w);
        blk_t m;
        for (int i = 0; i < 16; i++) m[i] = '0;
        m[0]  = (w == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
        m[15] = 64'h18;
        return m;
    endfunction

    // Loads a block at the current negedge and consumes n_beats words with
    // w_ready high ready_pct percent of the time. Returns at a negedge with
    // the DUT presenting word n_beats (or idle when n_beats == ROUNDS).
    task automatic stream_block(input int w, input blk_t m, input int n_beats,
                                input int ready_pct, output sched_t got);
        sched_t      ws;
        int          rounds, beats, cyc;
        logic        rdy, prev_rdy;
        logic [63:0] prev_data;
        sel64  = (w == 64);
        rounds = (w == 64) ? 80 : 64;
        build_sched(w, m, ws);
        for (int i = 0; i < 80; i++) got[i] = '0;
        blk_data  = pack(w, m);
        blk_valid = 1'b1;
        w_ready   = 1'b0;
        #1;
        checks++;
        if (obs_bready !== 1'b1)
            begin errors++; $display("FAIL load_ready w=%0d: block_ready=%b required 1", w, obs_bready); end
        @(negedge clock);
        blk_valid = 1'b0;
        beats = 0; cyc = 0; prev_rdy = 1'b1; prev_data = '0;
        while (beats < n_beats && cyc < 4000) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== ws[beats] || obs_index !== beats ||
                obs_last !== (beats == rounds - 1)) begin
                errors++;
                $display("FAIL word w=%0d t=%0d: valid=%b data=%h idx=%0d last=%b required valid=1 data=%h idx=%0d last=%b",
                         w, beats, obs_valid, obs_data, obs_index, obs_last, ws[beats], beats, beats == rounds - 1);
            end
            if (!prev_rdy) begin
                checks++;
                if (obs_data !== prev_data)
                    begin errors++; $display("FAIL stall_hold w=%0d t=%0d: data=%h required %h", w, beats, obs_data, prev_data); end
            end
            got[beats] = obs_data;
            rdy = ($urandom_range(0, 99) < ready_pct);
            w_ready = rdy;
            #1;
            checks++;
            if (obs_bready !== (rdy && beats == rounds - 1))
                begin errors++; $display("FAIL run_ready w=%0d t=%0d: block_ready=%b required %b", w, beats, obs_bready, rdy && beats == rounds - 1); end
            prev_rdy  = rdy;
            prev_data = obs_data;
            @(negedge clock);
            if (rdy) beats++;
            cyc++;
        end
        w_ready = 1'b0;
        if (beats < n_beats) begin
            checks++; errors++;
            $display("FAIL timeout w=%0d: beats=%0d required %0d", w, beats, n_beats);
        end
        if (n_beats == rounds) begin
            checks++;
            if (obs_valid !== 1'b0 || obs_busy !== 1'b0)
                begin errors++; $display("FAIL idle_after w=%0d: valid=%b busy=%b required 0 0", w, obs_valid, obs_busy); end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; abort = 1'b0; blk_valid = 1'b0; w_ready = 1'b0; sel64 = 1'b0;
        blk_data = '0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #1;
            checks++;
            if (obs_valid !== 0 || obs_last !== 0 || obs_busy !== 0 || obs_data !== 0 ||
                obs_index !== 0 || obs_bready !== 0)
                begin errors++; $display("FAIL reset_state sel=%0d: valid=%b last=%b busy=%b data=%h idx=%0d ready=%b required all 0",
                                         s, obs_valid, obs_last, obs_busy, obs_data, obs_index, obs_bready); end
        end
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            #1;
            checks++;
            if (obs_bready !== 1'b1)
                begin errors++; $display("FAIL reset_release sel=%0d: block_ready=%b required 1", s, obs_bready); end
        end
        @(negedge clock);
    endtask

    task automatic test_sha256_abc();
        sched_t got;
        stream_block(32, abc_block(32), 64, 100, got);
        checks++;
        if (got[0] !== 64'h61626380 || got[15] !== 64'h18 || got[16] !== 64'h61626380 || got[17] !== 64'h000F0000)
            begin errors++; $display("FAIL abc256_known: W0=%h W15=%h W16=%h W17=%h required 61626380 18 61626380 000f0000",
                                     got[0], got[15], got[16], got[17]); end
    endtask

    task automatic test_sha512_abc();
        sched_t got;
        stream_block(64, abc_block(64), 80, 100, got);
        checks++;
        if (got[16] !== 64'h6162638000000000)
            begin errors++; $display("FAIL abc512_w16: W16=%h required 6162638000000000", got[16]); end
        stream_block(64, rand_block(64), 80, 70, got);
    endtask

    task automatic test_random_ready();
        sched_t full, slow;
        stream_block(32, abc_block(32), 64, 100, full);
        stream_block(32, abc_block(32), 64, 50, slow);
        checks++;
        if (full != slow)
            begin errors++; $display("FAIL stall_sequence: stalled run W63=%h required %h", slow[63], full[63]); end
        stream_block(32, rand_block(32), 64, 40, slow);
    endtask

    task automatic test_back_to_back();
        blk_t   a, b;
        sched_t wa, wb;
        logic [63:0] exp;
        sel64 = 1'b0;
        a = rand_block(32); b = rand_block(32);
        build_sched(32, a, wa); build_sched(32, b, wb);
        blk_data = pack(32, a); blk_valid = 1'b1; w_ready = 1'b1;
        @(negedge clock);
        blk_data = pack(32, b);
        for (int k = 0; k < 128; k++) begin
            exp = (k < 64) ? wa[k] : wb[k-64];
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== exp || obs_index !== (k % 64))
                begin errors++; $display("FAIL b2b k=%0d: valid=%b data=%h idx=%0d required 1 %h %0d",
                                         k, obs_valid, obs_data, obs_index, exp, k % 64); end
            if (k == 63) begin
                #1;
                checks++;
                if (obs_bready !== 1'b1)
                    begin errors++; $display("FAIL b2b_ready: block_ready=%b required 1", obs_bready); end
            end
            if (k == 64) blk_valid = 1'b0;
            @(negedge clock);
        end
        w_ready = 1'b0;
        checks++;
        if (obs_valid !== 1'b0)
            begin errors++; $display("FAIL b2b_end: valid=%b required 0", obs_valid); end
    endtask

    task automatic test_abort();
        sched_t got;
        stream_block(32, rand_block(32), 20, 100, got);
        abort = 1'b1; blk_valid = 1'b1; blk_data = pack(32, rand_block(32)); w_ready = 1'b1;
        #1;
        checks++;
        if (obs_bready !== 1'b0)
            begin errors++; $display("FAIL abort_ready: block_ready=%b required 0", obs_bready); end
        @(negedge clock);
        abort = 1'b0; blk_valid = 1'b0; w_ready = 1'b0;
        checks++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_index !== 0)
            begin errors++; $display("FAIL abort_idle: valid=%b busy=%b idx=%0d required 0 0 0", obs_valid, obs_busy, obs_index); end
        stream_block(32, rand_block(32), 64, 100, got);
    endtask

    task automatic test_reset_mid_block();
        sched_t got;
        stream_block(32, rand_block(32), 40, 60, got);
        reset = 1'b1;
        #1;
        checks++;
        if (obs_bready !== 1'b0)
            begin errors++; $display("FAIL reset_ready: block_ready=%b required 0", obs_bready); end
        @(negedge clock);
        checks++;
        if (obs_valid !== 0 || obs_last !== 0 || obs_busy !== 0 || obs_data !== 0 || obs_index !== 0)
            begin errors++; $display("FAIL reset_mid: valid=%b last=%b busy=%b data=%h idx=%0d required all 0",
                                     obs_valid, obs_last, obs_busy, obs_data, obs_index); end
        reset = 1'b0;
        #1;
        checks++;
        if (obs_bready !== 1'b1)
            begin errors++; $display("FAIL reset_mid_release: block_ready=%b required 1", obs_bready); end
        @(negedge clock);
        stream_block(32, rand_block(32), 64, 100, got);
    endtask

    initial begin
        test_reset();
        test_sha256_abc();
        test_sha512_abc();
        test_random_ready();
        test_back_to_back();
        test_abort();
        test_reset_mid_block();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
